// File: rtl/spi_regbank.sv
// -----------------------------------------------------------------------------
// spi_regbank
//
// SPI slave control port for the synthesizer core, exposing a byte-wide bank
// of NUM_REGS writable registers plus one read-only status byte.
//
// Frame format (CS low for the whole frame):
//   byte 0      : command {rw, addr[6:0]}, MSB first, rw = 1 means read
//   byte 1..n   : data bytes; the address auto-increments after each byte,
//                 wrapping NUM_REGS-1 -> 0 inside the bank; status and
//                 out-of-range addresses count on mod 128 without wrapping.
//
// All SPI pins are brought into the clk domain through SYNC_STAGES-deep
// synchronisers, and SCK edges are detected on the synchronised copy, so
// SCK must run at clk/8 or slower.
//
// Optional feature (compile-time macro SPI_READBACK_EN):
//   defined     : read frames drive spi_miso from a snapshot shift register,
//                 with spi_miso_oe high from the read command until CS high.
//   not defined : spi_miso and spi_miso_oe are tied low; read frames are
//                 still decoded and still auto-increment the address.
//
// Parameters:
//   NUM_REGS     number of writable registers (1..127)
//   RESET_VALS   flat reset image, register i at [8i+7:8i]
//   STATUS_ADDR  read-only address returning status_in (>= NUM_REGS)
//   CPOL, CPHA   SPI mode; sample on rising edge when CPOL == CPHA
//   SYNC_STAGES  synchroniser depth (>= 2)
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   spi_sck         SPI clock pin
//   spi_cs          chip select pin, active low
//   spi_mosi        master-out data pin
//   spi_miso        slave-out data pin (0 while spi_miso_oe is low)
//   spi_miso_oe     output enable for the MISO pad
//   status_in       byte returned for reads of STATUS_ADDR
//   regs            flat register image, register i at [8i+7:8i]
//   wr_strobe       one-clk pulse per completed in-range register write
//   wr_addr         address of the most recent write, valid with wr_strobe
//
// Handshake: there is no backpressure. wr_strobe is a pure one-cycle event;
// consumers must sample regs/wr_addr in the cycle wr_strobe is high or rely
// on regs holding the value until the next write to that register.
// -----------------------------------------------------------------------------
module spi_regbank #(
  parameter int                    NUM_REGS    = 8,
  parameter logic [NUM_REGS*8-1:0] RESET_VALS  = '0,
  parameter logic [6:0]            STATUS_ADDR = 7'h7F,
  parameter int                    CPOL        = 0,
  parameter int                    CPHA        = 0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [7:0]            status_in,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr
);

  localparam logic [7:0] NUM_REGS_B  = 8'(NUM_REGS);
  localparam logic [6:0] LAST_ADDR   = 7'(NUM_REGS - 1);
  localparam bit         SAMPLE_RISE = (CPOL == CPHA);

  // ---------------------------------------------------------------------------
  // Pin synchronisers and SCK edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   sample_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [6:0] addr;
  logic [6:0] addr_inc;
  logic       addr_in_range;
  logic       take_bit;
  logic       byte_done;
  logic       wr_en;
  logic [NUM_REGS*8-1:0] reg_q;

  // A sample edge is accepted while CS is low, and also on the very clock
  // CS is seen rising if a frame is in progress, so an 8th bit that lands
  // together with CS high still completes its byte before returning to IDLE.
  assign take_bit  = sample_edge && (!cs_s || (state != S_IDLE));
  assign byte_done = take_bit && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi_s};

  assign addr_in_range = ({1'b0, addr} < NUM_REGS_B);
  // Inside the bank the address wraps; status/out-of-range just count mod 128.
  assign addr_inc = (addr_in_range && (addr == LAST_ADDR)) ? 7'd0 : addr + 7'd1;

  assign wr_en = byte_done && (state == S_WDATA) && addr_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (take_bit)  state_nx = S_CMD;
      S_CMD:   if (byte_done) state_nx = rx_byte[7] ? S_RDATA : S_WDATA;
      default: state_nx = state;
    endcase
    if (cs_s) state_nx = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Receive path, address counter and write strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      addr      <= 7'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (take_bit) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) begin
          bit_cnt <= 3'd0;
          case (state)
            S_CMD:   addr <= rx_byte[6:0];
            S_WDATA: begin
              if (addr_in_range) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
              end
              addr <= addr_inc;
            end
            S_RDATA: addr <= addr_inc;
            default: addr <= addr;
          endcase
        end
      end
      // A partial byte at CS high is simply forgotten.
      if (cs_s) bit_cnt <= 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= RESET_VALS;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == 7'(i)) reg_q[i*8 +: 8] <= rx_byte;
      end
    end
  end

  assign regs = reg_q;

  // ---------------------------------------------------------------------------
  // Read-back path
  // ---------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
  logic       shift_edge;
  logic       load_tx;
  logic [6:0] load_addr;
  logic [7:0] rd_byte;
  logic [7:0] tx_shift;
  logic       tx_skip;
  logic       oe_q;

  assign shift_edge = SAMPLE_RISE ? sck_fall : sck_rise;

  // Load at the command boundary of a read and at every read data boundary.
  // The command byte supplies the first address directly; afterwards the
  // next byte comes from the post-increment address.
  assign load_tx   = byte_done &&
                     (((state == S_CMD) && rx_byte[7]) || (state == S_RDATA));
  assign load_addr = (state == S_CMD) ? rx_byte[6:0] : addr_inc;

  always_comb begin
    rd_byte = 8'h00;
    if (load_addr == STATUS_ADDR) begin
      rd_byte = status_in;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_addr == 7'(i)) rd_byte = reg_q[i*8 +: 8];
      end
    end
  end

  // The shift edge right after a load is swallowed so bit 7 stays on MISO
  // for the next sample edge; this works identically for CPHA 0 and 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= 8'h00;
      tx_skip  <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      if (load_tx) begin
        tx_shift <= rd_byte;
        tx_skip  <= 1'b1;
        if (state == S_CMD) oe_q <= 1'b1;
      end else if (shift_edge && oe_q) begin
        if (tx_skip) tx_skip <= 1'b0;
        else         tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (cs_s) begin
        tx_shift <= 8'h00;
        tx_skip  <= 1'b0;
        oe_q     <= 1'b0;
      end
    end
  end

  assign spi_miso_oe = oe_q;
  assign spi_miso    = oe_q & tx_shift[7];
`else
  logic unused_status;
  assign unused_status = ^status_in;
  assign spi_miso_oe   = 1'b0;
  assign spi_miso      = 1'b0;
`endif

endmodule

// File: doc/spi_regbank.md
# spi_regbank

Parametrised SPI slave with a generic byte-wide register bank, the next-generation control port for the synthesizer core. It supports all four SPI modes, an N-register bank with reset values, burst auto-increment with wrap, a read-only status byte and, when compiled in, MISO read-back. It sits between the uio SPI pins and the oscillator, waveform and volume logic, replacing the fixed 7-register RX-only port.

## Interface
- NUM_REGS, 8: number of writable 8-bit registers (1..127), addresses 0..NUM_REGS-1
- RESET_VALS, 0: NUM_REGS*8-bit flat reset image; register i resets to RESET_VALS[8i+7:8i]
- STATUS_ADDR, 7'h7F: read-only address returning status_in; must be >= NUM_REGS
- CPOL, 0: idle SCK level
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge
- SYNC_STAGES, 2: synchroniser depth on SCK/CS/MOSI (>= 2)
- clk  in  1  system clock; SCK must be <= clk/8
- rst_n  in  1  asynchronous active-low reset
- spi_sck  in  1  SPI clock
- spi_cs  in  1  chip select, active low
- spi_mosi  in  1  master data in
- spi_miso  out  1  slave data out
- spi_miso_oe  out  1  MISO output enable (drives uio_oe)
- status_in  in  8  value returned at STATUS_ADDR
- regs  out  NUM_REGS*8  flat register image, register i at [8i+7:8i]
- wr_strobe  out  1  one-cycle pulse per completed register write
- wr_addr  out  7  address of last write, valid with wr_strobe

## Operation
- Frame: CS low, command byte {R/W, addr[6:0]} MSB first (1 = read), then any number of data bytes; CS high ends the frame.
- Sample edge: rising when CPOL == CPHA, else falling; shift edge is the opposite edge. Edges detected on synchronised SCK; edges while CS high are ignored.
- FSM: IDLE -> CMD on first sample edge with CS low; CMD -> WDATA or RDATA after the 8th bit; WDATA/RDATA loop per byte; any state -> IDLE when synchronised CS goes high.
- Bit counter: 3 bits, cleared on CS high and at every byte boundary.
- Write: on the 8th data bit, if addr < NUM_REGS, the register takes the byte and wr_strobe/wr_addr pulse. Writes to STATUS_ADDR or an out-of-range address are dropped with no strobe.
- Auto-increment: addr advances after every data byte (read or write), wrapping NUM_REGS-1 -> 0. STATUS_ADDR and out-of-range addresses increment without wrapping, mod 128.
- Read: at each byte boundary in a read frame, tx_shift loads regs[addr], status_in at STATUS_ADDR, or 0x00 out of range. The load is a snapshot. spi_miso = tx_shift[7]. The first shift edge after a load is suppressed; each later shift edge shifts left. This rule is uniform across all modes.
- spi_miso_oe = 1 from the command byte completing with R=1 until CS high; 0 otherwise. spi_miso = 0 when oe = 0.
- Partial byte at CS high: discarded, no write, no strobe.

## Timing
- Reset values: regs = RESET_VALS, wr_strobe = 0, wr_addr = 0, spi_miso = 0, spi_miso_oe = 0, FSM IDLE, counters 0, synchronisers CS = 1, others 0.
- Pin sample edge to register update and wr_strobe: SYNC_STAGES+1 clk. The strobe is high exactly 1 clk.
- CS pin rising to IDLE with oe low: SYNC_STAGES+1 clk.
- Read data valid on spi_miso within SYNC_STAGES+2 clk of the preceding sample edge.
- If CS rises on the same clk as the 8th sample edge, the byte completes first, then IDLE.
- Reset mid-frame: immediate return to reset values. The frame in progress is lost.

## Configuration
- SPI_READBACK_EN defined: read path, tx_shift, spi_miso and spi_miso_oe behave as described above.
- Not defined: spi_miso and spi_miso_oe tied 0. Read commands still enter RDATA and auto-increment, but nothing is driven or written. The tx logic is removed for area.

## Test plan
- Reset with RESET_VALS byte0 = 0x1C and byte5 = 0xFF -> regs reflect these immediately; no strobe.
- Mode 0, frame 0x02,0xAA,0xBB,0xCC -> regs 2..4 = AA,BB,CC; three wr_strobe pulses with wr_addr 2,3,4.
- NUM_REGS = 8, burst from 0x07 with 0x11,0x22 -> reg7 = 0x11, reg0 = 0x22 (wrap).
- Each of modes 1, 2 and 3, with SPI_READBACK_EN: write 0x5A to 0x01, then read frame 0x81 plus two dummy bytes -> MISO yields 0x5A then reg2. Read 0xFF (STATUS_ADDR) with status_in = 0x03 -> 0x03; out-of-range read -> 0x00.
- CS raised after 5 bits of a data byte -> register unchanged, no strobe, oe low within SYNC_STAGES+1 clk. The next frame decodes correctly.
- Write to STATUS_ADDR and to address 0x50 -> no register change, no strobe. rst_n pulsed mid-frame -> all outputs return to reset values.
